cnv_psum_quant: RTL and testbench

- Downstream stage of the MAC array.
- Accepts finished signed accumulator results (one per MAC completion) and adds a per-layer bias.
- Requantizes each result to DATA_WIDTH: arithmetic shift with round-half-up, optional ReLU, signed saturation.
- Packs NUM_PE results into one output word and buffers completed words in a small FIFO for the output buffer writer, using a valid/ready handshake on both sides.

---
 rtl/cnv_psum_quant.sv | 160 ++++++++++++++++
 tb/tb_cnv_psum_quant.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnv_psum_quant.sv
// Requantizes MAC accumulator results (bias, rounding shift, ReLU, saturation),
// packs NUM_PE lanes per word and queues finished words for the output writer.
module cnv_psum_quant #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAC_WIDTH   = 16,
  parameter int NUM_PE      = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         CFG_Sta,
  input  logic [MAC_WIDTH-1:0]         CFG_Bias,
  input  logic [SHIFT_WIDTH-1:0]       CFG_Shift,
  input  logic                         CFG_Relu,
  input  logic                         CNV_Val,
  output logic                         CNV_Rdy,
  input  logic [MAC_WIDTH-1:0]         CNV_Mac,
  input  logic                         CNV_Lst,
  output logic                         OUT_Val,
  input  logic                         OUT_Rdy,
  output logic [DATA_WIDTH*NUM_PE-1:0] OUT_Dat,
  output logic                         OUT_Lst
);

  localparam int CW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = MAC_WIDTH + 1;
  localparam int RW = MAC_WIDTH + 2;
  localparam int WW = DATA_WIDTH * NUM_PE;
  localparam logic [CW-1:0]        LAST_LANE = CW'(NUM_PE - 1);
  localparam logic [AW+1:0]        DEPTH     = (AW+2)'(FIFO_DEPTH);
  localparam logic signed [RW-1:0] SAT_MAX   = RW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] SAT_MIN   = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e                              state_q, state_d;
  logic [MAC_WIDTH-1:0]                bias_q;
  logic [SHIFT_WIDTH-1:0]              shift_q;
  logic                                relu_q;
  logic [CW-1:0]                       in_cnt_q;
  logic                                s1_vld_q, s1_lst_q, s1_cls_q;
  logic [SW-1:0]                       s1_sum_q;
  logic                                s2_vld_q, s2_lst_q, s2_cls_q;
  logic [DATA_WIDTH-1:0]               s2_dat_q;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]   pack_q, pack_d;
  logic [CW-1:0]                       pack_cnt_q, pack_cnt_d;
  logic                                done_q, done_d, wlst_q;
  logic [WW:0]                         mem_q [FIFO_DEPTH];
  logic [AW-1:0]                       wr_q, rd_q;
  logic [AW:0]                         cnt_q;

  logic                                accept, push, pop, in_cls, drained;
  logic [1:0]                          inflight;
  logic [AW+1:0]                       occupancy;
  logic [RW-1:0]                       ext, rnd;
  logic signed [RW-1:0]                shifted, clipped;
  logic [DATA_WIDTH-1:0]               quant;

  // A word is "in flight" once its closing element is accepted, so the FIFO
  // space it will need is reserved before the element is let in.
  assign inflight  = {1'b0, s1_vld_q & s1_cls_q} + {1'b0, s2_vld_q & s2_cls_q} + {1'b0, done_q};
  assign occupancy = {1'b0, cnt_q} + {{AW{1'b0}}, inflight};
  assign CNV_Rdy   = (state_q == RUN) && (occupancy < DEPTH);
  assign accept    = CNV_Val && CNV_Rdy;
  assign in_cls    = CNV_Lst || (in_cnt_q == LAST_LANE);
  assign push      = done_q;
  assign pop       = OUT_Val && OUT_Rdy;
  assign drained   = !s1_vld_q && !s2_vld_q && !done_q && (pack_cnt_q == '0) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (accept && CNV_Lst) state_d = DRAIN;
      DRAIN:   if (drained) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (CFG_Sta) state_d = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Round half up by adding half an LSB of the shifted result before the shift.
  assign ext     = {s1_sum_q[SW-1], s1_sum_q};
  assign rnd     = (shift_q == '0) ? '0 : (RW'(1) << (shift_q - 1'b1));
  assign shifted = $signed(ext + rnd) >>> shift_q;

  always_comb begin
    clipped = shifted;
    if (relu_q && shifted[RW-1]) clipped = '0;
    if (clipped > SAT_MAX)      clipped = SAT_MAX;
    else if (clipped < SAT_MIN) clipped = SAT_MIN;
  end
  assign quant = clipped[DATA_WIDTH-1:0];

  // The push cycle of a finished word may coincide with lane 0 of the next.
  always_comb begin
    pack_d     = done_q ? '0 : pack_q;
    pack_cnt_d = pack_cnt_q;
    done_d     = 1'b0;
    if (s2_vld_q) begin
      pack_d[pack_cnt_q] = s2_dat_q;
      if (s2_lst_q || (pack_cnt_q == LAST_LANE)) begin
        pack_cnt_d = '0;
        done_d     = 1'b1;
      end else begin
        pack_cnt_d = pack_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_q <= '0; shift_q <= '0; relu_q <= 1'b0; in_cnt_q <= '0;
      s1_vld_q <= 1'b0; s1_lst_q <= 1'b0; s1_cls_q <= 1'b0; s1_sum_q <= '0;
      s2_vld_q <= 1'b0; s2_lst_q <= 1'b0; s2_cls_q <= 1'b0; s2_dat_q <= '0;
      pack_q <= '0; pack_cnt_q <= '0; done_q <= 1'b0; wlst_q <= 1'b0;
      wr_q <= '0; rd_q <= '0; cnt_q <= '0;
    end else if (CFG_Sta) begin
      bias_q <= CFG_Bias; shift_q <= CFG_Shift; relu_q <= CFG_Relu; in_cnt_q <= '0;
      s1_vld_q <= 1'b0; s1_lst_q <= 1'b0; s1_cls_q <= 1'b0; s1_sum_q <= '0;
      s2_vld_q <= 1'b0; s2_lst_q <= 1'b0; s2_cls_q <= 1'b0; s2_dat_q <= '0;
      pack_q <= '0; pack_cnt_q <= '0; done_q <= 1'b0; wlst_q <= 1'b0;
      wr_q <= '0; rd_q <= '0; cnt_q <= '0;
    end else begin
      if (accept) in_cnt_q <= in_cls ? '0 : in_cnt_q + 1'b1;
      s1_vld_q <= accept;
      s1_lst_q <= CNV_Lst;
      s1_cls_q <= in_cls;
      s1_sum_q <= {CNV_Mac[MAC_WIDTH-1], CNV_Mac} + {bias_q[MAC_WIDTH-1], bias_q};
      s2_vld_q <= s1_vld_q;
      s2_lst_q <= s1_lst_q;
      s2_cls_q <= s1_cls_q;
      s2_dat_q <= quant;
      pack_q     <= pack_d;
      pack_cnt_q <= pack_cnt_d;
      done_q     <= done_d;
      wlst_q     <= s2_vld_q && s2_lst_q;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !CFG_Sta) mem_q[wr_q] <= {wlst_q, pack_q};
  end

  // Storage is not reset, so the read port is gated to keep outputs clean.
  assign OUT_Val = (cnt_q != '0);
  assign OUT_Dat = OUT_Val ? mem_q[rd_q][WW-1:0] : '0;
  assign OUT_Lst = OUT_Val ? mem_q[rd_q][WW] : 1'b0;

endmodule

// File: tb/tb_cnv_psum_quant.sv
// Directed bench for cnv_psum_quant: expected words are queued as stimulus is
// driven and compared against each word the output handshake delivers.
module tb_cnv_psum_quant;

  logic        clk, rst;
  logic        CFG_Sta, CFG_Relu;
  logic [15:0] CFG_Bias;
  logic [3:0]  CFG_Shift;
  logic        CNV_Val, CNV_Rdy, CNV_Lst;
  logic [15:0] CNV_Mac;
  logic        OUT_Val, OUT_Rdy, OUT_Lst;
  logic [31:0] OUT_Dat;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          popCount = 0;
  logic [32:0] sb[$];

  cnv_psum_quant #(
    .DATA_WIDTH(8), .MAC_WIDTH(16), .NUM_PE(4), .FIFO_DEPTH(4), .SHIFT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .CFG_Sta(CFG_Sta), .CFG_Bias(CFG_Bias), .CFG_Shift(CFG_Shift), .CFG_Relu(CFG_Relu),
    .CNV_Val(CNV_Val), .CNV_Rdy(CNV_Rdy), .CNV_Mac(CNV_Mac), .CNV_Lst(CNV_Lst),
    .OUT_Val(OUT_Val), .OUT_Rdy(OUT_Rdy), .OUT_Dat(OUT_Dat), .OUT_Lst(OUT_Lst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    assert (got === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every word leaving through the output handshake must match the queue head.
  always @(negedge clk) begin
    if (!rst && OUT_Val && OUT_Rdy) begin
      logic [32:0] exp;
      checkOutput("word_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checkOutput("out_dat", 64'(OUT_Dat), 64'(exp[31:0]));
        checkOutput("out_lst", 64'(OUT_Lst), 64'(exp[32]));
      end
      popCount++;
    end
  end

  task automatic applyStimulus(input logic [15:0] mac, input logic lst);
    int n = 0;
    CNV_Val = 1'b1; CNV_Mac = mac; CNV_Lst = lst;
    @(negedge clk);
    while (!CNV_Rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept_ready", 64'(CNV_Rdy), 64'd1);
    @(posedge clk); #1;
    CNV_Val = 1'b0; CNV_Lst = 1'b0;
  endtask

  task automatic startLayer(input logic [15:0] bias, input logic [3:0] shift, input logic relu);
    CFG_Sta = 1'b1; CFG_Bias = bias; CFG_Shift = shift; CFG_Relu = relu;
    sb.delete();
    @(posedge clk); #1;
    CFG_Sta = 1'b0;
  endtask

  task automatic waitEmpty(input int maxCycles);
    int n = 0;
    while (sb.size() != 0 && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, accepted, popStart, n;
    logic rdy;
    logic [7:0] base;
    rst = 1'b1; CFG_Sta = 1'b0; CFG_Bias = '0; CFG_Shift = '0; CFG_Relu = 1'b0;
    CNV_Val = 1'b0; CNV_Mac = '0; CNV_Lst = 1'b0; OUT_Rdy = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cnv_rdy", 64'(CNV_Rdy), 64'd0);
    checkOutput("reset_out_val", 64'(OUT_Val), 64'd0);
    checkOutput("reset_out_dat", 64'(OUT_Dat), 64'd0);
    checkOutput("reset_out_lst", 64'(OUT_Lst), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic packing and pipeline latency
    startLayer(16'd0, 4'd0, 1'b0);
    OUT_Rdy = 1'b1;
    applyStimulus(16'd1, 1'b0);
    applyStimulus(16'd2, 1'b0);
    applyStimulus(16'd3, 1'b0);
    sb.push_back({1'b0, 32'h04030201});
    applyStimulus(16'd4, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!OUT_Val && lat < 20);
    checkOutput("latency", 64'(lat), 64'd4);
    waitEmpty(50);

    // Bias and rounding shift
    startLayer(-16'sd44, 4'd2, 1'b0);
    sb.push_back({1'b1, 32'h00000040});
    applyStimulus(16'd300, 1'b1);
    waitEmpty(50);
    startLayer(16'd0, 4'd2, 1'b0);
    sb.push_back({1'b1, 32'h00FF0102});
    applyStimulus(16'd6, 1'b0);
    applyStimulus(16'd5, 1'b0);
    applyStimulus(-16'sd6, 1'b1);
    waitEmpty(50);

    // Saturation, then ReLU
    startLayer(16'd0, 4'd0, 1'b0);
    sb.push_back({1'b1, 32'h0000807F});
    applyStimulus(16'd2000, 1'b0);
    applyStimulus(-16'sd1000, 1'b1);
    waitEmpty(50);
    startLayer(16'd0, 4'd0, 1'b1);
    sb.push_back({1'b1, 32'h00000500});
    applyStimulus(-16'sd1000, 1'b0);
    applyStimulus(16'd5, 1'b1);
    waitEmpty(50);

    // Last flush with held output
    startLayer(16'd0, 4'd0, 1'b0);
    OUT_Rdy = 1'b0;
    sb.push_back({1'b1, 32'h00000201});
    applyStimulus(16'd1, 1'b0);
    applyStimulus(16'd2, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("drain_cnv_rdy", 64'(CNV_Rdy), 64'd0);
    checkOutput("drain_out_val", 64'(OUT_Val), 64'd1);
    checkOutput("drain_out_lst", 64'(OUT_Lst), 64'd1);
    @(posedge clk); #1;
    OUT_Rdy = 1'b1;
    waitEmpty(50);
    @(negedge clk);
    checkOutput("idle_cnv_rdy", 64'(CNV_Rdy), 64'd0);
    checkOutput("idle_out_val", 64'(OUT_Val), 64'd0);
    @(posedge clk); #1;

    // Backpressure: continuous input against a stalled output
    startLayer(16'd0, 4'd0, 1'b0);
    OUT_Rdy = 1'b0;
    accepted = 0;
    for (int c = 0; c < 60; c++) begin
      CNV_Val = 1'b1; CNV_Mac = 16'(accepted + 1); CNV_Lst = 1'b0;
      @(negedge clk);
      rdy = CNV_Rdy;
      @(posedge clk); #1;
      if (rdy) begin
        if (accepted % 4 == 3) begin
          base = 8'(accepted - 3);
          sb.push_back({1'b0, base + 8'd4, base + 8'd3, base + 8'd2, base + 8'd1});
        end
        accepted++;
      end
    end
    CNV_Val = 1'b0;
    @(negedge clk);
    checkOutput("bp_accepted", 64'(accepted), 64'd16);
    checkOutput("bp_cnv_rdy", 64'(CNV_Rdy), 64'd0);
    checkOutput("bp_held_dat", 64'(OUT_Dat), 64'h04030201);
    @(posedge clk); #1;
    popStart = popCount;
    OUT_Rdy = 1'b1;
    waitEmpty(100);
    checkOutput("bp_word_count", 64'(popCount - popStart), 64'd4);
    n = 0;
    while (!CNV_Rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_rdy_reasserts", 64'(CNV_Rdy), 64'd1);
    @(posedge clk); #1;

    // Restart mid-word discards both the queued word and the partial word
    startLayer(16'd0, 4'd0, 1'b0);
    OUT_Rdy = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(16'(9 + i), 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("restart_pre_val", 64'(OUT_Val), 64'd1);
    @(posedge clk); #1;
    startLayer(16'd0, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput("restart_fifo_empty", 64'(OUT_Val), 64'd0);
    @(posedge clk); #1;
    OUT_Rdy = 1'b1;
    sb.push_back({1'b0, 32'h14131211});
    for (int i = 0; i < 4; i++) applyStimulus(16'(8'h11 + i), 1'b0);
    waitEmpty(50);

    // Reset pulse mid-operation
    startLayer(16'd0, 4'd0, 1'b0);
    OUT_Rdy = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(16'(20 + i), 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("reset_pre_val", 64'(OUT_Val), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_out_val", 64'(OUT_Val), 64'd0);
    checkOutput("midreset_out_dat", 64'(OUT_Dat), 64'd0);
    checkOutput("midreset_cnv_rdy", 64'(CNV_Rdy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    startLayer(16'd0, 4'd0, 1'b0);
    OUT_Rdy = 1'b1;
    sb.push_back({1'b0, 32'h24232221});
    for (int i = 0; i < 4; i++) applyStimulus(16'(8'h21 + i), 1'b0);
    waitEmpty(50);
    @(negedge clk);
    checkOutput("final_out_val", 64'(OUT_Val), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
